// File: rtl/georgios_core.sv
// Two-stage execute core: decode register, 16-entry register file, add/sub ALU.
// Optional macro R0_ZERO_EN makes r0 a hard-wired zero register.
module georgios_core #(
  parameter int w       = 8,
  parameter int sel_w   = 4,
  parameter int flags_w = 6,
  parameter int op_w    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [op_w-1:0]      i0,
  input  logic [w-1:0]         i1,
  input  logic [w-1:0]         i2,
  input  logic [w-1:0]         i3,
  output logic [w-1:0]         result,
  output logic                 status,
  output logic [w-1:0]         x,
  output logic [w-1:0]         y,
  output logic [0:flags_w-1]   flags
);

  localparam logic [op_w-1:0] OP_NOP  = 3'd0;
  localparam logic [op_w-1:0] OP_ADD  = 3'd1;
  localparam logic [op_w-1:0] OP_SUB  = 3'd2;
  localparam logic [op_w-1:0] OP_ADDI = 3'd3;
  localparam logic [op_w-1:0] OP_SUBI = 3'd4;
  localparam logic [op_w-1:0] OP_LI   = 3'd5;
  localparam logic [op_w-1:0] OP_MOV  = 3'd6;
  localparam logic [op_w-1:0] OP_CMP  = 3'd7;

  localparam int nregs = 2 ** sel_w;

  logic [0:flags_w-1] flags_d;
  logic               alu_sub_d;

  logic [0:flags_w-1] flags_q;
  logic               alu_sub_q;
  logic [w-1:0]       i1_q;
  logic [w-1:0]       i2_q;
  logic [sel_w-1:0]   i3_q;

  logic [w-1:0]       r [nregs];

  logic               x_enb, y_enb, z_enb, b_imm, z_imm, st_enb;
  logic [sel_w-1:0]   sel_x, sel_y;
  logic [w-1:0]       rd_x, rd_y;
  logic [w-1:0]       alu_b;
  logic [w:0]         alu_full;
  logic [w-1:0]       wdata;
  logic               wr_en;

  // Flag order is x_enb, y_enb, z_enb, b_imm, z_imm, st_enb (bit 0 first).
  always_comb begin
    flags_d   = '0;
    alu_sub_d = 1'b0;
    case (i0)
      OP_NOP:  flags_d = 6'b000000;
      OP_ADD:  flags_d = 6'b111001;
      OP_SUB:  begin flags_d = 6'b111001; alu_sub_d = 1'b1; end
      OP_ADDI: flags_d = 6'b101101;
      OP_SUBI: begin flags_d = 6'b101101; alu_sub_d = 1'b1; end
      OP_LI:   flags_d = 6'b001010;
      OP_MOV:  flags_d = 6'b101000;
      OP_CMP:  begin flags_d = 6'b110001; alu_sub_d = 1'b1; end
      default: flags_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q   <= '0;
      alu_sub_q <= 1'b0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
    end else begin
      flags_q   <= flags_d;
      alu_sub_q <= alu_sub_d;
      i1_q      <= i1;
      i2_q      <= i2;
      i3_q      <= i3[sel_w-1:0];
    end
  end

  assign x_enb  = flags_q[0];
  assign y_enb  = flags_q[1];
  assign z_enb  = flags_q[2];
  assign b_imm  = flags_q[3];
  assign z_imm  = flags_q[4];
  assign st_enb = flags_q[5];

  assign sel_x = i1_q[sel_w-1:0];
  assign sel_y = i2_q[sel_w-1:0];

`ifdef R0_ZERO_EN
  assign rd_x  = (sel_x == '0) ? '0 : r[sel_x];
  assign rd_y  = (sel_y == '0) ? '0 : r[sel_y];
  assign wr_en = z_enb && (i3_q != '0);
`else
  assign rd_x  = r[sel_x];
  assign rd_y  = r[sel_y];
  assign wr_en = z_enb;
`endif

  assign x     = x_enb ? rd_x : '0;
  assign y     = y_enb ? rd_y : '0;
  // MOV has both b_imm and y_enb clear, so b collapses to zero.
  assign alu_b = b_imm ? i2_q : y;

  assign alu_full = alu_sub_q ? ({1'b0, x} - {1'b0, alu_b})
                              : ({1'b0, x} + {1'b0, alu_b});
  assign result   = alu_full[w-1:0];
  assign wdata    = z_imm ? i1_q : result;
  assign flags    = flags_q;

  // Reset wins over a pending writeback from the instruction in execute.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < nregs; i++) r[i] <= '0;
      status <= 1'b0;
    end else begin
      if (wr_en) r[i3_q] <= wdata;
      if (st_enb) status <= alu_full[w];
    end
  end

endmodule

// File: tb/tb_georgios_core.sv
// Scoreboard bench for georgios_core: directed vectors with hand-computed
// execute-stage outputs; a monitor pops one expectation per decode edge.
module tb_georgios_core;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] i0;
  logic [7:0] i1, i2, i3;
  logic [7:0] result;
  logic       status;
  logic [7:0] x, y;
  logic [0:5] flags;

  georgios_core dut (
    .clock (clock),
    .reset (reset),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .result(result),
    .status(status),
    .x     (x),
    .y     (y),
    .flags (flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [0:5] f;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [7:0] er;
    logic       es;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

`ifdef R0_ZERO_EN
  localparam logic [7:0] R0_RD = 8'h00;
`else
  localparam logic [7:0] R0_RD = 8'hAA;
`endif

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // Drives one cycle of inputs at the falling edge and records what the
  // execute stage must show right after the following rising edge.
  task automatic step(input logic rst, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c, input logic [0:5] ef,
                      input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] er,
                      input logic es, input string tag);
    exp_t e;
    @(negedge clock);
    reset = rst; i0 = op; i1 = a; i2 = b; i3 = c;
    e.f = ef; e.ex = ex; e.ey = ey; e.er = er; e.es = es; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".flags"},  {2'b00, flags}, {2'b00, e.f});
        check({e.tag, ".x"},      x,      e.ex);
        check({e.tag, ".y"},      y,      e.ey);
        check({e.tag, ".result"}, result, e.er);
        check({e.tag, ".status"}, {7'd0, status}, {7'd0, e.es});
      end
    end
  end

  initial begin : stim
    int waited;
    reset = 1'b1; i0 = 3'd1; i1 = 8'h01; i2 = 8'h02; i3 = 8'h03;
    //    rst op    i1     i2     i3     flags      x      y      result st  tag
    step(1, 3'd1, 8'h01, 8'h02, 8'h03, 6'b000000, 8'h00, 8'h00, 8'h00, 0, "rst0");
    step(1, 3'd1, 8'h01, 8'h02, 8'h03, 6'b000000, 8'h00, 8'h00, 8'h00, 0, "rst1");
    step(0, 3'd5, 8'h05, 8'h00, 8'h01, 6'b001010, 8'h00, 8'h00, 8'h00, 0, "li_r1");
    step(0, 3'd5, 8'h03, 8'h00, 8'h02, 6'b001010, 8'h00, 8'h00, 8'h00, 0, "li_r2");
    step(0, 3'd1, 8'h01, 8'h02, 8'h03, 6'b111001, 8'h05, 8'h03, 8'h08, 0, "add_r3");
    step(0, 3'd6, 8'h03, 8'h00, 8'h0A, 6'b101000, 8'h08, 8'h00, 8'h08, 0, "mov_r3");
    step(0, 3'd5, 8'hF0, 8'h00, 8'h01, 6'b001010, 8'h00, 8'h00, 8'h00, 0, "li_f0");
    step(0, 3'd3, 8'h01, 8'h20, 8'h04, 6'b101101, 8'hF0, 8'h00, 8'h10, 0, "addi_wrap");
    step(0, 3'd6, 8'h04, 8'h00, 8'h0B, 6'b101000, 8'h10, 8'h00, 8'h10, 1, "mov_r4");
    step(0, 3'd5, 8'h03, 8'h00, 8'h01, 6'b001010, 8'h00, 8'h00, 8'h00, 1, "li_r1b");
    step(0, 3'd5, 8'h05, 8'h00, 8'h02, 6'b001010, 8'h00, 8'h00, 8'h00, 1, "li_r2b");
    step(0, 3'd2, 8'h01, 8'h02, 8'h05, 6'b111001, 8'h03, 8'h05, 8'hFE, 1, "sub_borrow");
    step(0, 3'd7, 8'h02, 8'h01, 8'h05, 6'b110001, 8'h05, 8'h03, 8'h02, 1, "cmp");
    step(0, 3'd6, 8'h05, 8'h00, 8'h0C, 6'b101000, 8'hFE, 8'h00, 8'hFE, 0, "mov_r5");
    step(0, 3'd4, 8'h01, 8'h10, 8'h0D, 6'b101101, 8'h03, 8'h00, 8'hF3, 0, "subi");
    step(0, 3'd5, 8'h5A, 8'h00, 8'h17, 6'b001010, 8'h00, 8'h00, 8'h00, 1, "li_mask");
    step(0, 3'd6, 8'h07, 8'h00, 8'h08, 6'b101000, 8'h5A, 8'h00, 8'h5A, 1, "mov_r7");
    step(0, 3'd6, 8'h08, 8'h00, 8'h09, 6'b101000, 8'h5A, 8'h00, 8'h5A, 1, "mov_r8");
    step(0, 3'd5, 8'hAA, 8'h00, 8'h00, 6'b001010, 8'h00, 8'h00, 8'h00, 1, "li_r0");
    step(0, 3'd6, 8'h00, 8'h00, 8'h0E, 6'b101000, R0_RD, 8'h00, R0_RD, 1, "mov_r0");
    step(0, 3'd2, 8'h01, 8'h02, 8'h06, 6'b111001, 8'h03, 8'h05, 8'hFE, 1, "sub_pre_rst");
    step(1, 3'd1, 8'h01, 8'h02, 8'h03, 6'b000000, 8'h00, 8'h00, 8'h00, 0, "rst_mid");
    step(0, 3'd6, 8'h06, 8'h00, 8'h0F, 6'b101000, 8'h00, 8'h00, 8'h00, 0, "mov_r6");
    step(0, 3'd7, 8'h04, 8'h01, 8'h00, 6'b110001, 8'h00, 8'h00, 8'h00, 0, "cmp_post");
    step(0, 3'd0, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 8'h00, 0, "nop");

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: actual=%0d pending required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
